// File: rtl/snake_autopilot.sv
// Autopilot for the snake game: on each game step it decides whether to turn
// toward the fruit and then drives timed right/left press pulses for the game core.
module snake_autopilot #(
  parameter int PRESS_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int GRID_MAX_X   = 79,
  parameter int GRID_MAX_Y   = 59
) (
  input  logic       clock_25,
  input  logic       reset,
  input  logic       enable,
  input  logic       game_tik,
  input  logic       right,
  input  logic       left,
  input  logic       up,
  input  logic       down,
  input  logic [6:0] snake_head_x,
  input  logic [6:0] snake_head_y,
  input  logic [6:0] fruit_x,
  input  logic [6:0] fruit_y,
  output logic       right_P,
  output logic       left_P,
  output logic       busy,
  output logic       missed_tik,
  output logic [7:0] turn_count
);

  localparam int CNT_MAX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {IDLE, DECIDE, PRESS, GAP} state_t;
  typedef enum logic [1:0] {TURN_NONE, TURN_RIGHT, TURN_LEFT} turn_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             right_n, left_n, missed_n, latch_en;
  logic [7:0]       count_n;
  turn_t            turn;

  // Heading packed clockwise from +x: {right, down, left, up}
  logic [3:0] hdg_p0;
  logic [6:0] hx_p0, hy_p0, fx_p0, fy_p0;

  // Project the fruit offset onto the heading (ahead) and its clockwise normal (lateral).
  function automatic turn_t decide(input logic [3:0] hdg, input logic [6:0] hx,
                                   input logic [6:0] hy, input logic [6:0] fx,
                                   input logic [6:0] fy);
    logic signed [7:0] dx, dy, a, l;
    logic              valid, at_edge, cw_off;
    turn_t             t;
    dx      = $signed({1'b0, fx}) - $signed({1'b0, hx});
    dy      = $signed({1'b0, fy}) - $signed({1'b0, hy});
    a       = 8'sd0;
    l       = 8'sd0;
    valid   = 1'b1;
    at_edge = 1'b0;
    cw_off  = 1'b0;
    t       = TURN_NONE;
    case (hdg)
      4'b1000: begin a = dx;  l = dy;  at_edge = (hx == 7'(GRID_MAX_X)); cw_off = (hy == 7'(GRID_MAX_Y)); end
      4'b0100: begin a = dy;  l = -dx; at_edge = (hy == 7'(GRID_MAX_Y)); cw_off = (hx == 7'd0); end
      4'b0010: begin a = -dx; l = -dy; at_edge = (hx == 7'd0);           cw_off = (hy == 7'd0); end
      4'b0001: begin a = -dy; l = dx;  at_edge = (hy == 7'd0);           cw_off = (hx == 7'(GRID_MAX_X)); end
      default: valid = 1'b0;
    endcase
    if (valid) begin
      if (a > 8'sd0)      t = TURN_NONE;
      else if (l > 8'sd0) t = TURN_RIGHT;
      else if (l < 8'sd0) t = TURN_LEFT;
      else if (a < 8'sd0) t = TURN_RIGHT;
      // Heading straight into a wall: turn away, preferring clockwise.
      if (t == TURN_NONE && at_edge) t = cw_off ? TURN_LEFT : TURN_RIGHT;
    end
    return t;
  endfunction

  assign turn = decide(hdg_p0, hx_p0, hy_p0, fx_p0, fy_p0);
  assign busy = (state != IDLE);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    right_n  = right_P;
    left_n   = left_P;
    count_n  = turn_count;
    latch_en = 1'b0;
    missed_n = missed_tik | (game_tik && state != IDLE);
    case (state)
      IDLE: begin
        if (game_tik && enable) begin
          latch_en = 1'b1;
          state_n  = DECIDE;
        end
      end
      DECIDE: begin
        if (turn == TURN_RIGHT || turn == TURN_LEFT) begin
          right_n = (turn == TURN_RIGHT);
          left_n  = (turn == TURN_LEFT);
          cnt_n   = CNT_W'(PRESS_CYCLES - 1);
          count_n = turn_count + 8'd1;
          state_n = PRESS;
        end else begin
          state_n = IDLE;
        end
      end
      PRESS: begin
        if (cnt == '0) begin
          right_n = 1'b0;
          left_n  = 1'b0;
          cnt_n   = CNT_W'(GAP_CYCLES - 1);
          state_n = GAP;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock_25) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      right_P    <= 1'b0;
      left_P     <= 1'b0;
      turn_count <= 8'd0;
      missed_tik <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      right_P    <= right_n;
      left_P     <= left_n;
      turn_count <= count_n;
      missed_tik <= missed_n;
    end
  end

  // Stage p0: snapshot of the game state taken on the accepted step
  always_ff @(posedge clock_25) begin
    if (latch_en) begin
      hdg_p0 <= {right, down, left, up};
      hx_p0  <= snake_head_x;
      hy_p0  <= snake_head_y;
      fx_p0  <= fruit_x;
      fy_p0  <= fruit_y;
    end
  end

endmodule

// File: tb/tb_snake_autopilot.sv
// Bench for snake_autopilot: a vector-geometry timeline model checked every cycle,
// plus directed literal checks at hand-computed cycle offsets.
module tb_snake_autopilot;

  logic       clk = 1'b0;
  logic       rst, enable, game_tik, h_r, h_l, h_u, h_d;
  logic [6:0] hx, hy, fx, fy;
  logic       right_P, left_P, busy, missed_tik;
  logic [7:0] turn_count;

  int vectors = 0;
  int miscompares = 0;

  snake_autopilot dut (
    .clock_25(clk), .reset(rst), .enable(enable), .game_tik(game_tik),
    .right(h_r), .left(h_l), .up(h_u), .down(h_d),
    .snake_head_x(hx), .snake_head_y(hy), .fruit_x(fx), .fruit_y(fy),
    .right_P(right_P), .left_P(left_P), .busy(busy),
    .missed_tik(missed_tik), .turn_count(turn_count)
  );

  always #20 clk = ~clk;

  // Model state: e = index of the latest rising edge; s = edge that accepted a step.
  int         e = 0;
  int         s = -100;
  int         mturn = 0;   // 0 none, 1 right, 2 left
  logic [7:0] mcount = 8'd0;
  bit         mmissed = 1'b0;
  bit         started = 1'b0;

  function automatic bit off_grid(input int x, input int y);
    return (x < 0) || (x > 79) || (y < 0) || (y > 59);
  endfunction

  function automatic int model_turn(input logic r, input logic d, input logic lf,
                                    input logic u, input int phx, input int phy,
                                    input int pfx, input int pfy);
    int vx, vy, dx, dy, a, l, res;
    if (int'(r) + int'(d) + int'(lf) + int'(u) != 1) return 0;
    vx = r ? 1 : (lf ? -1 : 0);
    vy = d ? 1 : (u ? -1 : 0);
    dx = pfx - phx;
    dy = pfy - phy;
    a  = dx * vx + dy * vy;
    l  = dy * vx - dx * vy;
    if (a > 0)      res = 0;
    else if (l > 0) res = 1;
    else if (l < 0) res = 2;
    else if (a < 0) res = 1;
    else            res = 0;
    if (res == 0 && off_grid(phx + vx, phy + vy))
      res = off_grid(phx - vy, phy + vx) ? 2 : 1;
    return res;
  endfunction

  function automatic bit mbusy(input int p);
    if (mturn != 0) return (p >= s) && (p <= s + 8);
    return p == s;
  endfunction

  initial forever begin
    @(posedge clk);
    e = e + 1;
    if (rst) begin
      started = 1'b1;
      s = -100; mturn = 0; mcount = 8'd0; mmissed = 1'b0;
    end else begin
      if (mturn != 0 && e == s + 1) mcount = mcount + 8'd1;
      if (game_tik) begin
        if (mbusy(e - 1)) mmissed = 1'b1;
        else if (enable) begin
          s = e;
          mturn = model_turn(h_r, h_d, h_l, h_u, int'(hx), int'(hy), int'(fx), int'(fy));
        end
      end
    end
  end

  initial forever begin
    logic er, el, eb;
    @(negedge clk);
    if (started) begin
      er = (mturn == 1) && (e >= s + 1) && (e <= s + 4);
      el = (mturn == 2) && (e >= s + 1) && (e <= s + 4);
      eb = mbusy(e);
      vectors = vectors + 1;
      if (right_P !== er) begin miscompares++; $display("FAIL right_P cyc %0d: got %b want %b", e, right_P, er); end
      if (left_P !== el) begin miscompares++; $display("FAIL left_P cyc %0d: got %b want %b", e, left_P, el); end
      if (busy !== eb) begin miscompares++; $display("FAIL busy cyc %0d: got %b want %b", e, busy, eb); end
      if (missed_tik !== mmissed) begin miscompares++; $display("FAIL missed_tik cyc %0d: got %b want %b", e, missed_tik, mmissed); end
      if (turn_count !== mcount) begin miscompares++; $display("FAIL turn_count cyc %0d: got %0d want %0d", e, turn_count, mcount); end
      if (right_P === 1'b1 && left_P === 1'b1) begin miscompares++; $display("FAIL both_high cyc %0d: got 11 want not both", e); end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    vectors = vectors + 1;
    if (got !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Heading as {right, down, left, up}
  task automatic set_in(input logic [3:0] hd, input int ahx, input int ahy,
                        input int afx, input int afy);
    {h_r, h_d, h_l, h_u} = hd;
    hx = 7'(ahx); hy = 7'(ahy); fx = 7'(afx); fy = 7'(afy);
  endtask

  // Leaves the bench in the DECIDE cycle of the accepted step.
  task automatic tik();
    game_tik = 1'b1;
    step(1);
    game_tik = 1'b0;
  endtask

  localparam logic [3:0] HR = 4'b1000, HD = 4'b0100, HU = 4'b0001;

  initial begin
    rst = 1'b1; enable = 1'b0; game_tik = 1'b0;
    set_in(4'b0000, 0, 0, 0, 0);
    step(3);
    rst = 1'b0;
    chk("reset right_P", int'(right_P), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset turn_count", int'(turn_count), 0);
    enable = 1'b1;

    set_in(HR, 10, 10, 20, 10);
    tik();
    chk("ahead busy decide", int'(busy), 1);
    step(1);
    chk("ahead busy after", int'(busy), 0);
    chk("ahead no count", int'(turn_count), 0);
    step(2);

    set_in(HR, 10, 10, 5, 3);
    tik();
    step(1);
    chk("left first", int'(left_P), 1);
    chk("left right_P low", int'(right_P), 0);
    chk("left count", int'(turn_count), 1);
    step(3);
    chk("left last", int'(left_P), 1);
    step(1);
    chk("left ended", int'(left_P), 0);
    step(3);
    chk("gap busy", int'(busy), 1);
    step(1);
    chk("idle busy", int'(busy), 0);

    set_in(HU, 30, 20, 30, 40);
    tik();
    step(1);
    chk("behind right", int'(right_P), 1);
    step(4);
    chk("behind right ended", int'(right_P), 0);
    step(4);

    set_in(HR, 79, 5, 79, 5);
    tik();
    step(1);
    chk("wall right", int'(right_P), 1);
    step(8);
    set_in(HR, 79, 59, 79, 59);
    tik();
    step(1);
    chk("corner left", int'(left_P), 1);
    step(8);

    set_in(HR, 10, 10, 5, 3);
    tik();
    step(2);
    game_tik = 1'b1;
    step(1);
    game_tik = 1'b0;
    chk("missed set", int'(missed_tik), 1);
    chk("missed press kept", int'(left_P), 1);
    step(1);
    chk("missed press kept2", int'(left_P), 1);
    step(1);
    chk("missed press end", int'(left_P), 0);
    step(5);

    tik();
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("reset mid left_P", int'(left_P), 0);
    chk("reset mid count", int'(turn_count), 0);
    chk("reset mid missed", int'(missed_tik), 0);
    step(2);

    enable = 1'b0;
    tik();
    chk("disabled busy", int'(busy), 0);
    step(2);
    enable = 1'b1;

    set_in(HD, 40, 30, 50, 30);
    tik();
    step(2);
    enable = 1'b0;
    step(8);
    enable = 1'b1;

    set_in(4'b0000, 10, 10, 5, 3);
    tik();
    chk("no heading busy", int'(busy), 1);
    step(1);
    chk("no heading left", int'(left_P), 0);
    set_in(4'b1100, 10, 10, 5, 3);
    step(1);
    tik();
    step(1);
    chk("two hot left", int'(left_P), 0);
    chk("two hot right", int'(right_P), 0);
    step(1);

    rst = 1'b1;
    step(1);
    rst = 1'b0;
    set_in(HR, 10, 10, 5, 3);
    for (int i = 0; i < 256; i++) begin
      tik();
      step(9);
    end
    chk("wrap count", int'(turn_count), 0);
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
